// File: rtl/ser_pkg.sv
// Shared types and constants for the button-gated serial byte link (transmitter and receiver).
package ser_pkg;

    localparam int unsigned FRAME_BITS      = 8;
    localparam int unsigned SLOT_BITS       = 9;
    localparam int unsigned CNT_W           = $clog2(SLOT_BITS + 1);
    localparam int unsigned TO_W_DEFAULT    = 28;
    localparam logic [27:0] TIMEOUT_DEFAULT = 28'd100000000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GUARD = 2'd2
    } state_e;

    // True when the slot-9 bit makes the frame even parity.
    function automatic logic even_parity_ok(input logic [FRAME_BITS-1:0] data, input logic par);
        return ~((^data) ^ par);
    endfunction

endpackage

// File: rtl/ser_sync.sv
// N-stage (N >= 2) input synchroniser; optional rising-edge strobe derived from the synchronised value.
module ser_sync #(
    parameter int unsigned STAGES  = 2,
    parameter bit          EDGE_EN = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise_c
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

    if (EDGE_EN) begin : g_edge
        logic prev_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                prev_q <= 1'b0;
            end else begin
                prev_q <= q;
            end
        end

        assign rise_c = q & ~prev_q;
    end else begin : g_no_edge
        assign rise_c = 1'b0;
    end

endmodule

// File: rtl/ser_byte_rx.sv
// Serial byte receiver: MSB-first 8-bit frames in 9 clock slots, gated by SER_EN.
// Optional feature macro: SER_RX_PARITY_EN (slot 9 carries even parity and is checked).
module ser_byte_rx
    import ser_pkg::*;
#(
    parameter int unsigned     SYNC_STAGES    = 2,
    parameter int unsigned     TO_W           = TO_W_DEFAULT,
    parameter logic [TO_W-1:0] TIMEOUT_CYCLES = TO_W'(TIMEOUT_DEFAULT)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  SER_CLK,
    input  logic                  SER_DAT,
    input  logic                  SER_EN,
    output logic [FRAME_BITS-1:0] RX_DATA,
    output logic                  RX_VALID,
    output logic                  RX_ERR,
    output logic                  BUSY
);

    logic sclk_s;
    logic dat_s;
    logic en_s;
    logic sclk_rise_c;
    logic dat_rise_c;
    logic en_rise_c;
    logic unused;

    ser_sync #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_sync_clk (
        .clk    (CLK),
        .rst_n  (RST),
        .d      (SER_CLK),
        .q      (sclk_s),
        .rise_c (sclk_rise_c)
    );

    ser_sync #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_sync_dat (
        .clk    (CLK),
        .rst_n  (RST),
        .d      (SER_DAT),
        .q      (dat_s),
        .rise_c (dat_rise_c)
    );

    ser_sync #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_sync_en (
        .clk    (CLK),
        .rst_n  (RST),
        .d      (SER_EN),
        .q      (en_s),
        .rise_c (en_rise_c)
    );

    assign unused = ^{sclk_s, dat_rise_c, en_rise_c};

    state_e                state_q,   state_d;
    logic [CNT_W-1:0]      cnt_q,     cnt_d;
    logic [TO_W-1:0]       tcnt_q,    tcnt_d;
    logic [FRAME_BITS-1:0] shreg_q,   shreg_d;
    logic [FRAME_BITS-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  rx_err_q,  rx_err_d;
    logic                  busy_q,    busy_d;
    logic                  arm_q,     arm_d;

    logic                  timeout_c;
    logic [FRAME_BITS-1:0] shift_c;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            tcnt_q     <= '0;
            shreg_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
            busy_q     <= 1'b0;
            arm_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tcnt_q     <= tcnt_d;
            shreg_q    <= shreg_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_err_q   <= rx_err_d;
            busy_q     <= busy_d;
            arm_q      <= arm_d;
        end
    end

    // Next-state and output logic; an en_s drop takes priority over a coincident edge.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_err_d   = 1'b0;
        arm_d      = arm_q;
        shift_c    = {shreg_q[FRAME_BITS-2:0], dat_s};
        timeout_c  = (tcnt_q == (TIMEOUT_CYCLES - TO_W'(1)));

        if ((state_q == IDLE) || sclk_rise_c) begin
            tcnt_d = '0;
        end else if (tcnt_q != '1) begin
            tcnt_d = tcnt_q + TO_W'(1);
        end else begin
            tcnt_d = tcnt_q;
        end

        case (state_q)
            IDLE: begin
                // A new frame is accepted only after en_s has been seen low.
                if (!en_s) begin
                    arm_d = 1'b1;
                end else if (sclk_rise_c && arm_q) begin
                    shreg_d = shift_c;
                    cnt_d   = CNT_W'(1);
                    arm_d   = 1'b0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!en_s) begin
                    rx_err_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = IDLE;
                end else if (sclk_rise_c) begin
                    shreg_d = shift_c;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(FRAME_BITS - 1)) begin
                        state_d = GUARD;
`ifndef SER_RX_PARITY_EN
                        rx_data_d  = shift_c;
                        rx_valid_d = 1'b1;
`endif
                    end
                end else if (timeout_c) begin
                    rx_err_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = IDLE;
                end
            end
            GUARD: begin
                if (!en_s || timeout_c || sclk_rise_c) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
`ifdef SER_RX_PARITY_EN
                if (!en_s) begin
                    rx_err_d = 1'b1;
                end else if (sclk_rise_c) begin
                    if (even_parity_ok(shreg_q, dat_s)) begin
                        rx_data_d  = shreg_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        rx_err_d = 1'b1;
                    end
                end else if (timeout_c) begin
                    rx_err_d = 1'b1;
                end
`endif
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign RX_DATA  = rx_data_q;
    assign RX_VALID = rx_valid_q;
    assign RX_ERR   = rx_err_q;
    assign BUSY     = busy_q;

endmodule
